sys_arr_gemm_sequencer: RTL and testbench

Memory-side sequencer for the systolic array. It accepts a GEMM command, streams N weight rows and then one or more N-row input/partial-sum tiles into the array, and gates each tile on `fifo_has_space`. It forwards array output rows back to memory, counts them, and pulses `done` once every row of the command has returned and the array reports drained. Compared with the bare array link, it adds multi-tile streaming, weight reuse across commands, and completion tracking.

---
 rtl/sys_arr_pkg.sv | 17 +
 rtl/sys_arr_row_ctr.sv | 38 +++
 rtl/sys_arr_gemm_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_sys_arr_gemm_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared defaults and sequencer state type for the systolic array
// memory-side logic.
package sys_arr_pkg;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_WAIT_SPACE,
        S_LOAD_X,
        S_DRAIN
    } seq_state_t;

endpackage

// File: rtl/sys_arr_row_ctr.sv
// Wrapping row/tile counter with synchronous clear; N must be a power of 2
// so the increment wraps naturally at N-1.
module sys_arr_row_ctr #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 inc,
    input  logic                 clr,
    output logic [$clog2(N)-1:0] cnt,
    output logic                 last
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/sys_arr_gemm_sequencer.sv
// Memory-side GEMM sequencer: streams weight and input tiles into the
// systolic array and counts returning result rows until completion.
module sys_arr_gemm_sequencer #(
    parameter int N  = sys_arr_pkg::N,
    parameter int DW = sys_arr_pkg::DW,
    parameter int TW = sys_arr_pkg::TW
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [TW-1:0]        cmd_tiles,
    input  logic                 cmd_reuse_w,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DW*N-1:0]      w_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [DW*N-1:0]      x_data,
    input  logic [DW*N-1:0]      ps_data,
    output logic                 weight_en,
    output logic                 input_en,
    output logic                 partial_en,
    output logic [$clog2(N)-1:0] row_in_en,
    output logic [$clog2(N)-1:0] row_ps_en,
    output logic [DW*N-1:0]      array_in,
    output logic [DW*N-1:0]      array_in_partials,
    input  logic                 drained,
    input  logic                 fifo_has_space,
    input  logic                 out_en,
    input  logic [$clog2(N)-1:0] row_out,
    input  logic [DW*N-1:0]      array_output,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_row,
    output logic [DW*N-1:0]      res_data,
    output logic                 busy,
    output logic                 done
);

    import sys_arr_pkg::*;

    localparam int RW = $clog2(N);
    localparam int CW = TW + RW;

    seq_state_t state_q, state_d;

    logic [TW-1:0] tiles_q;
    logic          w_loaded_q;
    logic [CW-1:0] rows_rcvd_q;
    logic          done_q, done_d;

    logic [RW-1:0] row_cnt;
    logic          row_last;
    logic [TW-1:0] tile_cnt;
    logic          tile_wrap;

    logic cmd_fire, w_fire, x_fire;
    logic tile_final, rows_all;

    logic            weight_en_q, input_en_q, partial_en_q;
    logic [RW-1:0]   row_in_en_q, row_ps_en_q;
    logic [DW*N-1:0] array_in_q, array_ps_q;
    logic            res_valid_q;
    logic [RW-1:0]   res_row_q;
    logic [DW*N-1:0] res_data_q;

    assign cmd_fire = cmd_ready & cmd_valid;
    assign w_fire   = w_ready & w_valid;
    assign x_fire   = x_ready & x_valid;

    // tiles_q * N, with N a power of two
    assign rows_all   = (rows_rcvd_q == {tiles_q, {RW{1'b0}}});
    assign tile_final = (tile_cnt == tiles_q - 1'b1) | tile_wrap;

    sys_arr_row_ctr #(.N(N)) u_row_ctr (
        .clk  (clk),
        .nRST (nRST),
        .inc  (w_fire | x_fire),
        .clr  (cmd_fire),
        .cnt  (row_cnt),
        .last (row_last)
    );

    sys_arr_row_ctr #(.N(1 << TW)) u_tile_ctr (
        .clk  (clk),
        .nRST (nRST),
        .inc  (x_fire & row_last),
        .clr  (cmd_fire),
        .cnt  (tile_cnt),
        .last (tile_wrap)
    );

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        w_ready   = 1'b0;
        x_ready   = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_reuse_w && w_loaded_q) begin
                        state_d = S_WAIT_SPACE;
                    end else begin
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && row_last) begin
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (fifo_has_space) begin
                    state_d = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                x_ready = 1'b1;
                if (x_valid && row_last) begin
                    state_d = tile_final ? S_DRAIN : S_WAIT_SPACE;
                end
            end
            S_DRAIN: begin
                if (rows_all && drained) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            tiles_q     <= '0;
            w_loaded_q  <= 1'b0;
            rows_rcvd_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (cmd_fire) begin
                tiles_q <= (cmd_tiles == '0) ? TW'(1) : cmd_tiles;
            end
            if (w_fire && row_last) begin
                w_loaded_q <= 1'b1;
            end
            // Results arriving while idle are forwarded but not counted
            if (cmd_fire) begin
                rows_rcvd_q <= '0;
            end else if (busy && out_en) begin
                rows_rcvd_q <= rows_rcvd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            weight_en_q  <= 1'b0;
            input_en_q   <= 1'b0;
            partial_en_q <= 1'b0;
            row_in_en_q  <= '0;
            row_ps_en_q  <= '0;
            array_in_q   <= '0;
            array_ps_q   <= '0;
        end else begin
            weight_en_q  <= w_fire;
            input_en_q   <= x_fire;
            partial_en_q <= x_fire;
            row_in_en_q  <= (w_fire | x_fire) ? row_cnt : '0;
            row_ps_en_q  <= x_fire ? row_cnt : '0;
            if (w_fire) begin
                array_in_q <= w_data;
            end else if (x_fire) begin
                array_in_q <= x_data;
            end
            if (x_fire) begin
                array_ps_q <= ps_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= out_en;
            res_row_q   <= out_en ? row_out : '0;
            res_data_q  <= out_en ? array_output : '0;
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign weight_en         = weight_en_q;
    assign input_en          = input_en_q;
    assign partial_en        = partial_en_q;
    assign row_in_en         = row_in_en_q;
    assign row_ps_en         = row_ps_en_q;
    assign array_in          = array_in_q;
    assign array_in_partials = array_ps_q;
    assign res_valid         = res_valid_q;
    assign res_row           = res_row_q;
    assign res_data          = res_data_q;

endmodule

// File: tb/tb_sys_arr_gemm_sequencer.sv
// Randomized bench for the GEMM sequencer with a transaction-level model
// of rows/tiles outstanding and per-cycle output comparison.
`timescale 1ns/1ps
module tb_sys_arr_gemm_sequencer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam int RW = 2;
    localparam int BW = DW * N;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    logic cmd_valid, cmd_ready, cmd_reuse_w;
    logic [TW-1:0] cmd_tiles;
    logic w_valid, w_ready, x_valid, x_ready;
    logic [BW-1:0] w_data, x_data, ps_data;
    logic weight_en, input_en, partial_en;
    logic [RW-1:0] row_in_en, row_ps_en, row_out, res_row;
    logic [BW-1:0] array_in, array_in_partials, array_output, res_data;
    logic drained, fifo_has_space, out_en, res_valid, busy, done;

    always #5 clk = ~clk;

    sys_arr_gemm_sequencer #(.N(N), .DW(DW), .TW(TW)) dut (
        .clk(clk), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tiles(cmd_tiles), .cmd_reuse_w(cmd_reuse_w),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready),
        .x_data(x_data), .ps_data(ps_data),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en),
        .array_in(array_in), .array_in_partials(array_in_partials),
        .drained(drained), .fifo_has_space(fifo_has_space), .out_en(out_en),
        .row_out(row_out), .array_output(array_output),
        .res_valid(res_valid), .res_row(res_row), .res_data(res_data),
        .busy(busy), .done(done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_active, m_need, m_wres;
    int m_wleft, m_xleft, m_tleft, m_rexp, m_rgot;
    int edge_n = 0;
    int m_cmd_edge = 0;
    bit e_done, e_wen, e_xen, e_rv;
    logic [RW-1:0] e_rin, e_rps, e_rrow;
    logic [BW-1:0] e_ain, e_aps, e_rdata;

    wire e_cmd_ready = !m_active;
    wire e_w_ready = m_active && (m_wleft != 0);
    wire e_x_ready = m_active && (m_wleft == 0) && !m_need && (m_tleft != 0);

    task automatic mdl_reset();
        m_active = 0; m_need = 0; m_wres = 0;
        m_wleft = 0; m_xleft = 0; m_tleft = 0; m_rexp = 0; m_rgot = 0;
        e_done = 0; e_wen = 0; e_xen = 0; e_rv = 0;
        e_rin = '0; e_rps = '0; e_rrow = '0;
        e_ain = '0; e_aps = '0; e_rdata = '0;
    endtask

    task automatic mdl_step();
        bit wf, xf, cf;
        int got0, eff;
        wf = e_w_ready && w_valid;
        xf = e_x_ready && x_valid;
        cf = e_cmd_ready && cmd_valid;
        edge_n++;
        e_wen = wf;
        e_xen = xf;
        e_rin = wf ? RW'(N - m_wleft) : (xf ? RW'(N - m_xleft) : '0);
        e_rps = xf ? RW'(N - m_xleft) : '0;
        if (wf) e_ain = w_data;
        else if (xf) e_ain = x_data;
        if (xf) e_aps = ps_data;
        e_rv = out_en;
        e_rrow = row_out;
        e_rdata = array_output;
        e_done = 0;
        got0 = m_rgot;
        if (m_active && out_en) m_rgot++;
        if (cf) begin
            eff = (cmd_tiles == 0) ? 1 : int'(cmd_tiles);
            m_active = 1;
            m_cmd_edge = edge_n;
            m_tleft = eff;
            m_rexp = eff * N;
            m_rgot = 0;
            m_wleft = (cmd_reuse_w && m_wres) ? 0 : N;
            m_xleft = N;
            m_need = 1;
        end else if (m_active) begin
            if (wf) begin
                m_wleft--;
                if (m_wleft == 0) m_wres = 1;
            end else if (m_wleft == 0 && m_need) begin
                if (fifo_has_space) m_need = 0;
            end else if (xf) begin
                m_xleft--;
                if (m_xleft == 0) begin
                    m_tleft--;
                    m_xleft = N;
                    m_need = (m_tleft != 0);
                end
            end else if (m_tleft == 0 && got0 == m_rexp && drained) begin
                m_active = 0;
                e_done = 1;
            end
        end
    endtask

    always @(posedge clk or negedge nRST) begin
        if (!nRST) mdl_reset();
        else mdl_step();
    end

    always @(negedge clk) begin
        if (nRST) begin
            chk("cmd_ready", cmd_ready, e_cmd_ready);
            chk("w_ready", w_ready, e_w_ready);
            chk("x_ready", x_ready, e_x_ready);
            chk("busy", busy, m_active);
            chk("done", done, e_done);
            chk("weight_en", weight_en, e_wen);
            chk("input_en", input_en, e_xen);
            chk("partial_en", partial_en, e_xen);
            chk("row_in_en", row_in_en, e_rin);
            chk("row_ps_en", row_ps_en, e_rps);
            chk("array_in", array_in, e_ain);
            chk("array_in_partials", array_in_partials, e_aps);
            chk("res_valid", res_valid, e_rv);
            if (e_rv) begin
                chk("res_row", res_row, e_rrow);
                chk("res_data", res_data, e_rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    int p_w, p_x, p_sp, p_out, p_dr;
    int beats_left, beats_sent, beats_at_done, last_beat_edge;
    int stall_left, stall_tleft, stall_cycles, stall_xr;
    bit stalling;
    int w_seen, x_seen, wr_seen, done_seen, done_edge;
    int first_w, last_w, first_x, last_x;

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic clr_stats();
        w_seen = 0; x_seen = 0; wr_seen = 0; done_seen = 0; done_edge = 0;
        first_w = 0; last_w = 0; first_x = 0; last_x = 0;
        beats_sent = 0; beats_at_done = 0; last_beat_edge = 0;
        stall_cycles = 0; stall_xr = 0; stalling = 0;
    endtask

    task automatic drive();
        w_valid = pct(p_w);
        w_data = {$urandom, $urandom};
        x_valid = pct(p_x);
        x_data = {$urandom, $urandom};
        ps_data = {$urandom, $urandom};
        stalling = 0;
        if (stall_left > 0 && m_active && m_need && m_wleft == 0 &&
            m_tleft == stall_tleft) begin
            fifo_has_space = 1'b0;
            stall_left--;
            stall_cycles++;
            stalling = 1;
        end else begin
            fifo_has_space = pct(p_sp);
        end
        drained = pct(p_dr);
        row_out = RW'($urandom);
        array_output = {$urandom, $urandom};
        if (m_active && beats_left > 0 && pct(p_out)) begin
            out_en = 1'b1;
            beats_left--;
            beats_sent++;
            last_beat_edge = edge_n + 1;
        end else begin
            out_en = !m_active && pct(10);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        if (weight_en) begin
            if (w_seen == 0) first_w = edge_n;
            last_w = edge_n;
            w_seen++;
        end
        if (input_en) begin
            if (x_seen == 0) first_x = edge_n;
            last_x = edge_n;
            x_seen++;
        end
        if (w_ready) wr_seen++;
        if (stalling && x_ready) stall_xr++;
        if (done) begin
            done_seen++;
            done_edge = edge_n;
            beats_at_done = beats_sent;
        end
        drive();
    endtask

    task automatic run_cmd(input int tiles, input bit reuse);
        int eff;
        int guard;
        eff = (tiles == 0) ? 1 : tiles;
        clr_stats();
        beats_left = eff * N;
        cmd_valid = 1'b1;
        cmd_tiles = TW'(tiles);
        cmd_reuse_w = reuse;
        guard = 0;
        while (done_seen == 0 && guard < 3000) begin
            cycle();
            if (m_active) cmd_valid = 1'b0;
            guard++;
        end
        cmd_valid = 1'b0;
        repeat (3) cycle();
        chk("done_pulses", done_seen, 1);
        chk("beats_at_done", beats_at_done, eff * N);
    endtask

    task automatic knobs(input int w, input int x, input int sp,
                         input int o, input int dr);
        p_w = w; p_x = x; p_sp = sp; p_out = o; p_dr = dr;
    endtask

    initial begin
        int guard;
        cmd_valid = 0; cmd_tiles = '0; cmd_reuse_w = 0;
        w_valid = 0; x_valid = 0; w_data = '0; x_data = '0; ps_data = '0;
        drained = 0; fifo_has_space = 0; out_en = 0;
        row_out = '0; array_output = '0;
        stall_left = 0; stall_tleft = 0;
        knobs(100, 100, 100, 100, 100);
        clr_stats();
        repeat (3) @(negedge clk);
        #1 nRST = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_weight_en", weight_en, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_array_in", array_in, 0);

        // back-to-back single tile, fresh weights
        run_cmd(1, 0);
        chk("t1_w_rows", w_seen, 4);
        chk("t1_first_w", first_w - m_cmd_edge, 1);
        chk("t1_last_w", last_w - m_cmd_edge, 4);
        chk("t1_first_x", first_x - m_cmd_edge, 6);
        chk("t1_last_x", last_x - m_cmd_edge, 9);

        // resident weights reused
        knobs(70, 70, 60, 60, 60);
        run_cmd(2, 1);
        chk("reuse_w_ready", wr_seen, 0);
        chk("reuse_w_beats", w_seen, 0);

        // space withheld five cycles before tile 2
        knobs(100, 100, 100, 50, 100);
        stall_left = 5;
        stall_tleft = 2;
        run_cmd(3, 1);
        chk("stall_cycles", stall_cycles, 5);
        chk("stall_x_ready", stall_xr, 0);
        stall_left = 0;

        // zero tiles acts as one
        knobs(80, 80, 80, 70, 70);
        run_cmd(0, $urandom_range(1));
        chk("t0_x_rows", x_seen, 4);

        // drained early while rows still outstanding
        knobs(100, 100, 100, 15, 100);
        run_cmd(2, 1);
        chk("drain_after_rows", done_edge > last_beat_edge, 1);

        // reset in the middle of an input tile
        knobs(100, 100, 100, 0, 100);
        clr_stats();
        beats_left = 0;
        cmd_valid = 1'b1;
        cmd_tiles = TW'(2);
        cmd_reuse_w = 1'b0;
        guard = 0;
        while (!(m_active && m_wleft == 0 && !m_need && m_xleft < N) &&
               guard < 200) begin
            cycle();
            if (m_active) cmd_valid = 1'b0;
            guard++;
        end
        cmd_valid = 1'b0;
        chk("rst_reached_load_x", guard < 200, 1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_input_en", input_en, 0);
        chk("rst_partial_en", partial_en, 0);
        chk("rst_row_in_en", row_in_en, 0);
        chk("rst_array_in", array_in, 0);
        chk("rst_partials", array_in_partials, 0);
        repeat (2) @(negedge clk);
        #1 nRST = 1'b1;
        done_seen = 0;
        repeat (4) cycle();
        chk("rst_no_done", done_seen, 0);
        knobs(100, 100, 100, 100, 100);
        run_cmd(1, 1);
        chk("rst_reload_w", w_seen, 4);

        // random commands
        for (int i = 0; i < 20; i++) begin
            knobs($urandom_range(30, 100), $urandom_range(30, 100),
                  $urandom_range(30, 100), $urandom_range(30, 100),
                  $urandom_range(20, 100));
            run_cmd($urandom_range(0, 5), $urandom_range(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
